shifter_operand_decoder: RTL and testbench

Sequential decode-phase front end for the data-processing barrel shifter. It accepts an ARM data-processing instruction word and the current C flag, reads Rs and Rm from the register file through a single synchronous read port, and presents the barrel shifter's operand bundle: data, 8-bit shift amount, shift operation and carry-in. It applies the ARM immediate-encoding rules, so the downstream shifter receives only canonical operations: LSR/ASR #0 becomes 32, ROR #0 becomes RRX with a nonzero amount, and the rotated 8-bit immediate uses ROR by 2×rotate_imm.

---
 rtl/shifter_operand_decoder.sv | 212 +++++++++++++++++++++
 tb/tb_shifter_operand_decoder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_operand_decoder.sv
`timescale 1ns/1ps
// Decode-phase front end for the barrel shifter: turns a data-processing instruction into a canonical
// operand bundle, reading Rs/Rm over one synchronous port. Optional undef check: SHIFTER_OPERAND_UNDEF_CHECK_EN.
module shifter_operand_decoder #(
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic                  in_carry_flag,
    output logic                  rf_rd_en,
    output logic [REG_ADDR_W-1:0] rf_rd_addr,
    input  logic [31:0]           rf_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_data,
    output logic [7:0]            out_shift_value,
    output logic [2:0]            out_op_select,
    output logic                  out_carry,
    output logic                  out_undef,
    output logic [2:0]            dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // out_* are held stable while out_valid is high and out_ready is low.

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RS_REQ = 3'd1,
        ST_RM_REQ = 3'd2,
        ST_RM_CAP = 3'd3,
        ST_OUT    = 3'd4
    } state_t;

    localparam logic [2:0] OP_LSL = 3'b000;
    localparam logic [2:0] OP_LSR = 3'b001;
    localparam logic [2:0] OP_ASR = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_RRX = 3'b100;

    state_t      state_q, state_d;
    logic [3:0]  rs_q, rs_d;
    logic [3:0]  rm_q, rm_d;
    logic        reg_shift_q, reg_shift_d;
    logic [31:0] out_data_q, out_data_d;
    logic [7:0]  out_shift_value_q, out_shift_value_d;
    logic [2:0]  out_op_select_q, out_op_select_d;
    logic        out_carry_q, out_carry_d;
    logic        out_undef_q, out_undef_d;

    logic        accept;
    logic        is_imm;
    logic        is_undef;
    logic        is_reg;
    logic [4:0]  shift_imm;
    logic [1:0]  shift_type;
    logic [7:0]  s_amount;
    logic [2:0]  s_op;
    logic        unused_instr_bits;

    assign unused_instr_bits = ^{in_instr[31:26], in_instr[24:12]};

    assign accept     = in_valid && in_ready;
    assign is_imm     = in_instr[25];
    assign shift_imm  = in_instr[11:7];
    assign shift_type = in_instr[6:5];

`ifdef SHIFTER_OPERAND_UNDEF_CHECK_EN
    assign is_undef = !in_instr[25] && in_instr[4] && in_instr[7];
`else
    assign is_undef = 1'b0;
`endif

    assign is_reg = !in_instr[25] && in_instr[4] && !is_undef;

    // Immediate-shift canonicalisation: #0 means 32 for LSR/ASR and RRX for ROR.
    always_comb begin
        s_amount = {3'b000, shift_imm};
        s_op     = OP_LSL;
        case (shift_type)
            2'b00: s_op = OP_LSL;
            2'b01: begin
                s_op = OP_LSR;
                if (shift_imm == 5'd0) s_amount = 8'd32;
            end
            2'b10: begin
                s_op = OP_ASR;
                if (shift_imm == 5'd0) s_amount = 8'd32;
            end
            default: begin
                if (shift_imm == 5'd0) begin
                    s_op     = OP_RRX;
                    s_amount = 8'd1;
                end else begin
                    s_op = OP_ROR;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_imm || is_undef) state_d = ST_OUT;
                    else if (is_reg)        state_d = ST_RS_REQ;
                    else                    state_d = ST_RM_REQ;
                end
            end
            ST_RS_REQ: state_d = ST_RM_REQ;
            ST_RM_REQ: state_d = ST_RM_CAP;
            ST_RM_CAP: state_d = ST_OUT;
            ST_OUT:    if (out_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == ST_IDLE) && !rst;
        out_valid  = (state_q == ST_OUT);
        rf_rd_en   = 1'b0;
        rf_rd_addr = '0;
        if (!rst) begin
            if (state_q == ST_RS_REQ) begin
                rf_rd_en   = 1'b1;
                rf_rd_addr = REG_ADDR_W'(rs_q);
            end else if (state_q == ST_RM_REQ) begin
                rf_rd_en   = 1'b1;
                rf_rd_addr = REG_ADDR_W'(rm_q);
            end
        end
    end

    always_comb begin
        rs_d              = rs_q;
        rm_d              = rm_q;
        reg_shift_d       = reg_shift_q;
        out_data_d        = out_data_q;
        out_shift_value_d = out_shift_value_q;
        out_op_select_d   = out_op_select_q;
        out_carry_d       = out_carry_q;
        out_undef_d       = out_undef_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rs_d        = in_instr[11:8];
                    rm_d        = in_instr[3:0];
                    reg_shift_d = is_reg;
                    out_carry_d = in_carry_flag;
                    out_undef_d = is_undef;
                    out_data_d  = 32'd0;
                    if (is_imm) begin
                        out_data_d        = {24'd0, in_instr[7:0]};
                        out_shift_value_d = {3'b000, in_instr[11:8], 1'b0};
                        out_op_select_d   = OP_ROR;
                    end else if (is_undef) begin
                        out_shift_value_d = 8'd0;
                        out_op_select_d   = OP_LSL;
                    end else if (is_reg) begin
                        out_shift_value_d = 8'd0;
                        out_op_select_d   = {1'b0, shift_type};
                    end else begin
                        out_shift_value_d = s_amount;
                        out_op_select_d   = s_op;
                    end
                end
            end
            // Rs data returns while Rm is being requested.
            ST_RM_REQ: if (reg_shift_q) out_shift_value_d = rf_rd_data[7:0];
            ST_RM_CAP: out_data_d = rf_rd_data;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs_q              <= 4'd0;
            rm_q              <= 4'd0;
            reg_shift_q       <= 1'b0;
            out_data_q        <= 32'd0;
            out_shift_value_q <= 8'd0;
            out_op_select_q   <= OP_LSL;
            out_carry_q       <= 1'b0;
            out_undef_q       <= 1'b0;
        end else begin
            rs_q              <= rs_d;
            rm_q              <= rm_d;
            reg_shift_q       <= reg_shift_d;
            out_data_q        <= out_data_d;
            out_shift_value_q <= out_shift_value_d;
            out_op_select_q   <= out_op_select_d;
            out_carry_q       <= out_carry_d;
            out_undef_q       <= out_undef_d;
        end
    end

    assign out_data        = out_data_q;
    assign out_shift_value = out_shift_value_q;
    assign out_op_select   = out_op_select_q;
    assign out_carry       = out_carry_q;
    assign out_undef       = out_undef_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_shifter_operand_decoder.sv
`timescale 1ns/1ps
// Self-checking bench for shifter_operand_decoder: behavioural register file plus an instruction-level
// reference model; directed cases from the operand rules followed by randomized back-to-back traffic.
module tb_shifter_operand_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        in_carry_flag;
    logic        rf_rd_en;
    logic [3:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_shift_value;
    logic [2:0]  out_op_select;
    logic        out_carry;
    logic        out_undef;
    logic [2:0]  dbg_state;

    logic [31:0] regs [16];
    logic [44:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    shifter_operand_decoder #(.REG_ADDR_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_carry_flag(in_carry_flag),
        .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_shift_value(out_shift_value), .out_op_select(out_op_select),
        .out_carry(out_carry), .out_undef(out_undef), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Synchronous-read register file: data appears the cycle after the strobe.
    always @(posedge clk) if (rf_rd_en) rf_rd_data <= regs[rf_rd_addr];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [44:0] dut_bundle();
        return {out_data, out_shift_value, out_op_select, out_carry, out_undef};
    endfunction

    function automatic bit undef_enc(input logic [31:0] ins);
`ifdef SHIFTER_OPERAND_UNDEF_CHECK_EN
        return !ins[25] && ins[4] && ins[7];
`else
        return 1'b0;
`endif
    endfunction

    // Bundle: {data, amount, op, carry, undef}. Ops: 0 LSL, 1 LSR, 2 ASR, 3 ROR, 4 RRX.
    function automatic logic [44:0] model_bundle(input logic [31:0] ins, input logic c);
        logic [31:0] d;
        logic [7:0]  a;
        logic [2:0]  op;
        logic        u;
        logic [31:0] rs_val;
        int          sh;
        u = 1'b0;
        if (ins[25]) begin
            d  = ins & 32'h0000_00FF;
            a  = 8'(2 * int'(ins[11:8]));
            op = 3'd3;
        end else if (undef_enc(ins)) begin
            d = 32'd0; a = 8'd0; op = 3'd0; u = 1'b1;
        end else if (ins[4]) begin
            rs_val = regs[ins[11:8]];
            d  = regs[ins[3:0]];
            a  = 8'(rs_val % 256);
            op = {1'b0, ins[6:5]};
        end else begin
            d  = regs[ins[3:0]];
            sh = int'(ins[11:7]);
            op = {1'b0, ins[6:5]};
            a  = 8'(sh);
            if (sh == 0 && (op == 3'd1 || op == 3'd2)) a = 8'd32;
            if (sh == 0 && op == 3'd3) begin
                op = 3'd4;
                a  = 8'd1;
            end
        end
        return {d, a, op, c, u};
    endfunction

    function automatic int model_latency(input logic [31:0] ins);
        if (ins[25] || undef_enc(ins)) return 1;
        if (ins[4]) return 4;
        return 3;
    endfunction

    // Entered and left just after a falling edge. hold = cycles of out_ready=0 while out_valid is up.
    task automatic run_txn(input logic [31:0] ins, input logic c, input int hold);
        logic [44:0] exp_b;
        logic [44:0] got_b;
        logic [7:0]  exp_rd[$];
        logic [7:0]  got_rd[$];
        int          lat;
        int          got_lat;
        int          k;
        exp_q.push_back(model_bundle(ins, c));
        lat = model_latency(ins);
        if (!ins[25] && !undef_enc(ins)) begin
            if (ins[4]) begin
                exp_rd.push_back({4'd1, ins[11:8]});
                exp_rd.push_back({4'd2, ins[3:0]});
            end else begin
                exp_rd.push_back({4'd1, ins[3:0]});
            end
        end
        out_ready     = 1'b0;
        in_valid      = 1'b1;
        in_instr      = ins;
        in_carry_flag = c;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL accept_ready: in_ready=%b expected 1", in_ready);
        end
        @(negedge clk);
        in_valid      = 1'b0;
        in_instr      = $urandom;
        in_carry_flag = 1'($urandom_range(0, 1));
        got_lat = 0;
        k = 1;
        while (got_lat == 0 && k <= 8) begin
            if (rf_rd_en) got_rd.push_back({4'(k), rf_rd_addr});
            if (out_valid) begin
                got_lat = k;
            end else begin
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_errors++;
                    $display("FAIL busy_ready: in_ready=%b expected 0 at cycle %0d", in_ready, k);
                end
                @(negedge clk);
                k++;
            end
        end
        n_checks++;
        if (got_lat != lat) begin
            n_errors++;
            $display("FAIL latency: instr=%h got %0d expected %0d (0 = timeout)", ins, got_lat, lat);
        end
        exp_b = exp_q.pop_front();
        if (got_lat == 0) return;
        got_b = dut_bundle();
        n_checks++;
        if (got_b !== exp_b) begin
            n_errors++;
            $display("FAIL bundle: instr=%h got %h expected %h", ins, got_b, exp_b);
        end
        n_checks++;
        if (got_rd.size() != exp_rd.size()) begin
            n_errors++;
            $display("FAIL read_count: instr=%h got %0d expected %0d", ins, got_rd.size(), exp_rd.size());
        end else begin
            foreach (exp_rd[i]) begin
                n_checks++;
                if (got_rd[i] !== exp_rd[i]) begin
                    n_errors++;
                    $display("FAIL read_seq: instr=%h {cycle,addr} got %h expected %h", ins, got_rd[i], exp_rd[i]);
                end
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            n_checks++;
            if (dut_bundle() !== exp_b || out_valid !== 1'b1 || in_ready !== 1'b0 || rf_rd_en !== 1'b0) begin
                n_errors++;
                $display("FAIL hold: cycle %0d bundle=%h valid=%b in_ready=%b rd_en=%b expected %h/1/0/0",
                         h, dut_bundle(), out_valid, in_ready, rf_rd_en, exp_b);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL release: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_instr = 32'd0; in_carry_flag = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        n_checks++;
        if (dut_bundle() !== 45'd0 || out_valid !== 1'b0 || rf_rd_en !== 1'b0 || rf_rd_addr !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: bundle=%h valid=%b rd_en=%b addr=%h expected all 0",
                     dut_bundle(), out_valid, rf_rd_en, rf_rd_addr);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release: in_ready=%b expected 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_immediate();
        run_txn(32'h02A0_04FF, 1'b1, 0);
        run_txn(32'hE3A0_0F01, 1'b0, 0);
    endtask

    task automatic test_imm_shift();
        regs[2] = 32'h8000_0001;
        run_txn(32'hE1A0_0022, 1'b0, 0);
        run_txn(32'hE1A0_0062, 1'b1, 0);
        run_txn(32'hE1A0_0002, 1'b1, 0);
    endtask

    task automatic test_reg_shift();
        regs[3] = 32'h0000_0121;
        regs[4] = 32'hDEAD_BEEF;
        run_txn(32'hE1A0_0354, 1'b0, 0);
        regs[5] = 32'h0000_0000;
        run_txn(32'hE1A0_0575, 1'b1, 0);
        regs[6] = 32'h0000_0004;
        run_txn(32'hE1A0_6616, 1'b0, 0);
    endtask

    task automatic test_back_pressure();
        regs[7] = 32'h1234_5678;
        run_txn(32'hE1A0_0287, 1'b1, 10);
        run_txn(32'h02A0_0C3C, 1'b0, 10);
    endtask

    task automatic test_reset_mid();
        regs[9] = 32'hCAFE_F00D;
        in_valid = 1'b1; in_instr = 32'hE1A0_0109; in_carry_flag = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_in_ready: got %b expected 0", in_ready);
        end
        @(negedge clk);
        n_checks++;
        if (dut_bundle() !== 45'd0 || out_valid !== 1'b0 || rf_rd_en !== 1'b0 || rf_rd_addr !== 4'd0) begin
            n_errors++;
            $display("FAIL midrst_outputs: bundle=%h valid=%b rd_en=%b addr=%h expected all 0",
                     dut_bundle(), out_valid, rf_rd_en, rf_rd_addr);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst_release: in_ready=%b expected 1", in_ready);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (rf_rd_en !== 1'b0 || out_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL midrst_quiet: cycle %0d rd_en=%b out_valid=%b expected 0/0", i, rf_rd_en, out_valid);
            end
        end
    endtask

    task automatic test_undef();
        regs[3] = 32'h0000_00A5;
        regs[4] = 32'h0F0F_0F0F;
        run_txn(32'hE000_0394, 1'b1, 0);
        run_txn(32'hE1A0_03F4, 1'b0, 2);
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins;
        for (int n = 0; n < 40; n++) begin
            for (int r = 0; r < 16; r++)
                regs[r] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            ins = $urandom;
            run_txn(ins, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
    endtask

    initial begin
        for (int r = 0; r < 16; r++) regs[r] = $urandom;
        test_reset();
        test_immediate();
        test_imm_shift();
        test_reg_shift();
        test_back_pressure();
        test_reset_mid();
        test_undef();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
